// File: rtl/ph_sched_pkg.sv
// rtl/ph_sched_pkg.sv - shared state encoding and sizing helpers for ph_write_sched
package ph_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        STROBE    = 3'd2,
        HOLD      = 3'd3,
        WAIT_FULL = 3'd4
    } state_e;

    // Wide enough for STROBE_CYCLES-1 with STROBE_CYCLES up to 15.
    localparam int STB_CNT_W = 4;

    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ph_write_sched_if.sv
// rtl/ph_write_sched_if.sv - parasite-to-host byte register bus
interface ph_write_sched_if;
    logic [7:0] p_data;
    logic       p_selectData;
    logic       p_westb_b;
    logic       p_full;

    modport master (
        output p_data,
        output p_selectData,
        output p_westb_b,
        input  p_full
    );

    modport slave (
        input  p_data,
        input  p_selectData,
        input  p_westb_b,
        output p_full
    );
endinterface

// File: rtl/ph_rr_arb.sv
// rtl/ph_rr_arb.sv - combinational round-robin pick: first set req at or after ptr
module ph_rr_arb
    import ph_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]            req,
    input  logic [gid_width(NREQ)-1:0] ptr,
    output logic [gid_width(NREQ)-1:0] winner,
    output logic                       valid
);

    localparam int GW = gid_width(NREQ);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/ph_write_sched.sv
// rtl/ph_write_sched.sv - round-robin scheduler for the parasite-to-host byte register
// Optional WAIT_FULL watchdog and timeout_err output under PH_WRITE_SCHED_TIMEOUT_EN.
module ph_write_sched
    import ph_sched_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int STROBE_CYCLES = 1,
    parameter int TIMEOUT       = 1023
) (
    input  logic                       p_clk,
    input  logic                       h_rst_b,
    input  logic [NREQ-1:0]            req,
    input  logic [8*NREQ-1:0]          req_data,
    output logic [NREQ-1:0]            ack,
    output logic                       busy,
    output logic [gid_width(NREQ)-1:0] grant_id,
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
    output logic                       timeout_err,
`endif
    ph_write_sched_if.master           pbus
);

    localparam int GW = gid_width(NREQ);
    localparam logic [STB_CNT_W-1:0] STB_LOAD = STB_CNT_W'(STROBE_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [GW-1:0]          gid_q, gid_d;
    logic [7:0]             data_q, data_d;
    logic [STB_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   sel_q, sel_d;
    logic                   westb_q, westb_d;
    logic                   busy_q, busy_d;
    logic [NREQ-1:0]        ack_q, ack_d;

    logic [GW-1:0]          win_id;
    logic                   win_vld;

`ifdef PH_WRITE_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]        wd_q, wd_d;
    logic                   terr_q, terr_d;
`else
    wire unused_timeout = (TIMEOUT > 0);
`endif

    ph_rr_arb #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win_id),
        .valid  (win_vld)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
        wd_d    = wd_q;
        terr_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!pbus.p_full && win_vld) begin
                    data_d  = req_data[8*win_id +: 8];
                    gid_d   = win_id;
                    ptr_d   = (win_id == GW'(NREQ - 1)) ? '0 : win_id + 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = STB_LOAD;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                state_d = WAIT_FULL;
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT_FULL: begin
                // Waiting for p_full guarantees the flag reflects our write before the next grant.
                if (pbus.p_full) begin
                    state_d = IDLE;
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    terr_d  = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus outputs are decoded from the next state so they come straight from flops.
        sel_d   = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        westb_d = (state_d != STROBE);
        busy_d  = (state_d != IDLE);
        if (state_d == HOLD) begin
            ack_d[gid_d] = 1'b1;
        end
    end

    always_ff @(posedge p_clk or negedge h_rst_b) begin
        if (!h_rst_b) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            data_q  <= 8'h00;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            westb_q <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= '0;
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
            wd_q    <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            westb_q <= westb_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
            wd_q    <= wd_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign pbus.p_data       = data_q;
    assign pbus.p_selectData = sel_q;
    assign pbus.p_westb_b    = westb_q;
    assign ack               = ack_q;
    assign busy              = busy_q;
    assign grant_id          = gid_q;
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
    assign timeout_err       = terr_q;
`endif

endmodule

// File: tb/tb_ph_write_sched.sv
// tb/tb_ph_write_sched.sv - self-checking bench for ph_write_sched
module tb_ph_write_sched;

    localparam int NREQ = 4;
    localparam int STB  = 1;
    localparam int TMO  = 15;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] g;
    } exp_t;

    typedef struct packed {
        logic [3:0]  r;
        logic [31:0] d;
        logic [1:0]  g;
        logic [7:0]  b;
    } vec_t;

    logic                 p_clk = 1'b0;
    logic                 h_rst_b = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      req3 = '0;
    logic [8*NREQ-1:0]    req_data = '0;
    logic [8*NREQ-1:0]    req_data3 = '0;
    logic [NREQ-1:0]      ack, ack3;
    logic                 busy, busy3;
    logic [1:0]           grant_id, grant3;
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
    logic                 timeout_err, timeout_err3;
`endif

    ph_write_sched_if pif ();
    ph_write_sched_if pif3 ();

    ph_write_sched #(.NREQ(NREQ), .STROBE_CYCLES(STB), .TIMEOUT(TMO)) u_dut (
        .p_clk       (p_clk),
        .h_rst_b     (h_rst_b),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .busy        (busy),
        .grant_id    (grant_id),
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
        .timeout_err (timeout_err),
`endif
        .pbus        (pif.master)
    );

    ph_write_sched #(.NREQ(NREQ), .STROBE_CYCLES(3), .TIMEOUT(TMO)) u_dut3 (
        .p_clk       (p_clk),
        .h_rst_b     (h_rst_b),
        .req         (req3),
        .req_data    (req_data3),
        .ack         (ack3),
        .busy        (busy3),
        .grant_id    (grant3),
`ifdef PH_WRITE_SCHED_TIMEOUT_EN
        .timeout_err (timeout_err3),
`endif
        .pbus        (pif3.master)
    );

    always #5 p_clk = ~p_clk;

    int   chk = 0;
    int   fails = 0;
    exp_t sbq[$];
    logic host_auto = 1'b1;
    int   full_age = 0;
    logic prev_westb = 1'b1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        chk++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Host/register model and scoreboard monitor: a capture is the rising edge of p_westb_b.
    always @(negedge p_clk) begin
        if (!h_rst_b) begin
            prev_westb = 1'b1;
        end else begin
            if (!pif.p_westb_b) check("no_strobe_when_full", {31'd0, pif.p_full}, 32'd0);
            if (pif.p_westb_b && !prev_westb) begin
                check("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
                if (sbq.size() != 0) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("wr_data", {24'd0, pif.p_data}, {24'd0, e.b});
                    check("wr_gid", {30'd0, grant_id}, {30'd0, e.g});
                    check("wr_ack", {28'd0, ack}, 32'd1 << e.g);
                    check("wr_sel", {31'd0, pif.p_selectData}, 32'd1);
                end
                if (host_auto) begin
                    pif.p_full = 1'b1;
                    full_age   = 0;
                end
            end else if (host_auto && pif.p_full) begin
                full_age++;
                if (full_age >= 5) pif.p_full = 1'b0;
            end
            prev_westb = pif.p_westb_b;
            req = req & ~ack;
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy || pif.p_full || sbq.size() != 0) && n < 300) begin
            @(negedge p_clk);
            n++;
        end
        check(nm, {31'd0, n < 300}, 32'd1);
    endtask

    task automatic do_xfer(input logic [3:0] r, input logic [31:0] d, input logic [1:0] g,
                           input logic [7:0] b, input string nm);
        int lat;
        exp_t e;
        e.b = b;
        e.g = g;
        sbq.push_back(e);
        req_data = d;
        req      = r;
        lat      = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge p_clk);
            if (ack != '0) begin
                lat = n;
                req = '0;
                break;
            end
        end
        check({nm, "_lat"}, lat, 2 + STB);
        check({nm, "_busy"}, {31'd0, busy}, 32'd1);
        wait_idle({nm, "_idle"});
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b0001, 32'h443322A5, 2'd0, 8'hA5};
        vecs[1] = '{4'b0001, 32'h00000017, 2'd0, 8'h17};
        vecs[2] = '{4'b1001, 32'hC3C2C1C0, 2'd3, 8'hC3};
        vecs[3] = '{4'b1010, 32'hD3D2D1D0, 2'd1, 8'hD1};
        vecs[4] = '{4'b0011, 32'hE3E2E1E0, 2'd0, 8'hE0};
        vecs[5] = '{4'b0110, 32'hF3F2F1F0, 2'd1, 8'hF1};
        vecs[6] = '{4'b1111, 32'h03020100, 2'd2, 8'h02};
        vecs[7] = '{4'b1111, 32'h13121110, 2'd3, 8'h13};

        pif.p_full  = 1'b0;
        pif3.p_full = 1'b0;
        #12;
        check("rst_westb", {31'd0, pif.p_westb_b}, 32'd1);
        check("rst_sel", {31'd0, pif.p_selectData}, 32'd0);
        check("rst_data", {24'd0, pif.p_data}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_gid", {30'd0, grant_id}, 32'd0);
        #10;
        h_rst_b = 1'b1;
        @(negedge p_clk);

        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i].r, vecs[i].d, vecs[i].g, vecs[i].b, $sformatf("vec%0d", i));
        end

        // All four requesting at once: served in order, each waiting for the host read.
        req_data = 32'h44332211;
        sbq.push_back('{8'h11, 2'd0});
        sbq.push_back('{8'h22, 2'd1});
        sbq.push_back('{8'h33, 2'd2});
        sbq.push_back('{8'h44, 2'd3});
        req = 4'b1111;
        wait_idle("burst_idle");
        check("burst_req_cleared", {28'd0, req}, 32'd0);

        // Register full blocks the grant entirely.
        begin
            int lo, ak;
            host_auto   = 1'b0;
            pif.p_full  = 1'b1;
            req_data    = 32'h00770000;
            req         = 4'b0100;
            lo = 0;
            ak = 0;
            for (int n = 0; n < 50; n++) begin
                @(negedge p_clk);
                if (!pif.p_westb_b) lo++;
                if (ack != '0) ak++;
            end
            check("blocked_strobe", lo, 0);
            check("blocked_ack", ak, 0);
            check("blocked_busy", {31'd0, busy}, 32'd0);
            sbq.push_back('{8'h77, 2'd2});
            pif.p_full = 1'b0;
            host_auto  = 1'b1;
            wait_idle("blocked_release_idle");
        end

        // Asynchronous reset in the middle of STROBE.
        req_data = 32'h0000005A;
        req      = 4'b0001;
        @(negedge p_clk);
        @(negedge p_clk);
        check("rst_mid_pre_strobe", {31'd0, pif.p_westb_b}, 32'd0);
        #2;
        h_rst_b = 1'b0;
        req     = '0;
        #1;
        check("rst_mid_westb", {31'd0, pif.p_westb_b}, 32'd1);
        check("rst_mid_sel", {31'd0, pif.p_selectData}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_data", {24'd0, pif.p_data}, 32'd0);
        @(negedge p_clk);
        #2;
        h_rst_b = 1'b1;
        @(negedge p_clk);
        do_xfer(4'b0011, 32'h0000BBAA, 2'd0, 8'hAA, "post_rst");

`ifdef PH_WRITE_SCHED_TIMEOUT_EN
        begin
            int n;
            host_auto = 1'b0;
            sbq.push_back('{8'hB2, 2'd1});
            sbq.push_back('{8'hB1, 2'd0});
            req_data = 32'h0000B2B1;
            req      = 4'b0011;
            n = 0;
            while (ack == '0 && n < 30) begin
                @(negedge p_clk);
                n++;
            end
            check("tmo_first_ack", {31'd0, n < 30}, 32'd1);
            n = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge p_clk);
                if (timeout_err) begin
                    n = k;
                    break;
                end
            end
            check("tmo_latency", n, 16);
            @(negedge p_clk);
            check("tmo_pulse_one", {31'd0, timeout_err}, 32'd0);
            wait_idle("tmo_idle");
            host_auto = 1'b1;
        end
`endif

        // Longer strobe on the second instance.
        begin
            int lo, sl, lat;
            req_data3 = 32'h0000003C;
            req3      = 4'b0001;
            lo = 0;
            sl = 0;
            lat = 0;
            for (int n = 1; n <= 30; n++) begin
                @(negedge p_clk);
                if (!pif3.p_westb_b) lo++;
                if (pif3.p_selectData) sl++;
                if (ack3 != '0 && lat == 0) begin
                    lat         = n;
                    req3        = '0;
                    pif3.p_full = 1'b1;
                    check("s3_data", {24'd0, pif3.p_data}, 32'h3C);
                end
            end
            check("s3_strobe_low", lo, 3);
            check("s3_sel_high", sl, 5);
            check("s3_lat", lat, 5);
            check("s3_busy_done", {31'd0, busy3}, 32'd0);
            pif3.p_full = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench did not finish");
    end

endmodule

// File: doc/ph_write_sched.md
Name: ph_write_sched

Overview:
- Parasite-side scheduler that shares the single parasite-to-host byte register between NREQ on-chip requesters.
- Requesters include the CPU write path, a block-transfer engine and a status injector.
- Arbitrates round-robin and sequences the p_selectData / p_westb_b write strobe so data lands on the rising edge of p_westb_b.
- Uses the register's p_full flag so the register is never overwritten before the host has read it.

Parameters:
- NREQ, 4, number of requesters (2..8).
- STROBE_CYCLES, 1, p_clk cycles p_westb_b is held low (1..15).
- TIMEOUT, 1023, WAIT_FULL watchdog limit in p_clk cycles (used only with the optional feature).

Ports:
- p_clk  in  1  parasite clock; all state on posedge.
- h_rst_b  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester write request, level, held until ack.
- req_data  in  8*NREQ  byte for requester i on bits [8i+7:8i].
- ack  out  NREQ  one-cycle pulse: requester's byte has been written.
- p_full  in  1  byte-register full flag (1 = host has not yet read).
- p_data  out  8  byte presented to the register.
- p_selectData  out  1  register select.
- p_westb_b  out  1  write strobe, active-low; data captured on its rising edge.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  clog2(NREQ)  index of the current/last granted requester.

Behaviour:
- Reset values: p_westb_b=1, p_selectData=0, p_data=8'h00, ack=0, busy=0, grant_id=0, rr pointer=0, state=IDLE, strobe counter=0.
- Reset is asynchronous and takes effect mid-transfer; p_westb_b returns high immediately. The byte register shares reset, so no data is captured.
- IDLE:
  - If p_full==0 and |req, pick the winner: the first set req at or after the rr pointer, wrapping modulo NREQ.
  - Latch req_data[winner] into p_data and set grant_id=winner. Set rr pointer to (winner+1) mod NREQ, wrapping to 0 at NREQ-1. Go to SETUP.
  - If p_full==1, no grant.
- SETUP (1 cycle): p_selectData=1, p_westb_b=1, p_data stable. Go to STROBE.
- STROBE (STROBE_CYCLES cycles): p_selectData=1, p_westb_b=0. A counter counts down; when it reaches 0, go to HOLD.
- HOLD (1 cycle): p_westb_b=1, which is the capture edge; p_selectData=1 and p_data held. ack[grant_id]=1 this cycle. Go to WAIT_FULL.
- WAIT_FULL: p_selectData=0, p_westb_b=1. Stay until p_full==1, then go to IDLE. This guarantees the flag has reflected the write before the next grant is considered.
- Grant latency: request seen in IDLE to ack = 2+STROBE_CYCLES cycles.
- Minimum spacing between writes is gated by the host read clearing p_full.
- req dropping mid-transfer: the transfer completes with the latched byte and ack still pulses. The requester must ignore a stray ack.
- req_data changing after grant has no effect; the byte was latched in IDLE.
- A requester whose req stays high after its ack is eligible again only after the others, per the rr pointer.
- NREQ=1 degenerates to a simple sequencer.
- p_full rising outside WAIT_FULL (another writer) only blocks the IDLE grant.
- p_data retains its last value outside transfers.

Optional Feature:
- Macro PH_WRITE_SCHED_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (1 bit, reset 0) and a watchdog counter cleared on entry to WAIT_FULL.
  - If p_full is not seen within TIMEOUT cycles, pulse timeout_err for 1 cycle and return to IDLE.
  - The ack already issued stands.
- When undefined: WAIT_FULL waits indefinitely, and neither the port nor the counter exists.

Decomposition:
- Package ph_sched_pkg:
  - state encoding constants: IDLE, SETUP, STROBE, HOLD, WAIT_FULL;
  - grant-index width function;
  - STROBE counter width.
- One sub-module, ph_rr_arb: combinational round-robin winner select from req and pointer. It outputs winner index and a valid flag; the pointer register stays in ph_write_sched.

Test Plan:
- Reset, then req=4'b0001, req_data[7:0]=8'hA5, p_full=0 -> p_westb_b low 1 cycle; p_data=A5 at its rising edge; ack[0] pulses 3 cycles after grant; busy until p_full driven 1.
- req=4'b1111 with data 11,22,33,44; host model clears p_full 5 cycles after each set -> writes occur in order 11,22,33,44 with grant_id 0,1,2,3; no write while p_full=1.
- p_full held 1, req=4'b0100 -> no strobe and no ack for 50 cycles; release p_full -> write of requester 2 follows.
- STROBE_CYCLES=3 -> p_westb_b low exactly 3 cycles; p_selectData high 5 cycles per transfer.
- Assert h_rst_b=0 during STROBE -> p_westb_b=1 and p_selectData=0 asynchronously; after release, state IDLE and rr pointer 0.
- With PH_WRITE_SCHED_TIMEOUT_EN and TIMEOUT=15: p_full never rises -> timeout_err pulses on the 16th WAIT_FULL cycle and the next pending req is granted.
